// File: rtl/adc_wave_pkg.sv
// Shared types and constants for the ADC waveform capture buffer.
package adc_wave_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    WAIT_TRIG,
    POST,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    RD_ZERO,
    RD_SAMPLE,
    RD_STATUS
  } rd_sel_t;

  localparam int CTRL_ARM     = 0;
  localparam int CTRL_FALLING = 1;
  localparam int CTRL_FORCE   = 2;
  localparam int CTRL_CLEAR   = 3;

  localparam logic [15:0] STATUS_ADDR = 16'hFFFF;

endpackage

// File: rtl/adc_wave_ram.sv
// Simple dual-port sample memory: one write port, one registered read port.
module adc_wave_ram #(
  parameter int DEPTH = 1024,
  parameter int ADC_W = 14,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [ADC_W-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [ADC_W-1:0] o_rdata
);

  logic [ADC_W-1:0] r_mem [DEPTH];
  logic [ADC_W-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/adc_wave_buffer.sv
// Triggered waveform capture: records ADC samples around a level crossing
// (or a forced trigger) and serves them to a CPU through a PIO read port.
module adc_wave_buffer
  import adc_wave_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int ADC_W = 14,
  parameter int PRETRIG = 128,
  parameter logic [ADC_W-1:0] TRIG_LEVEL = 14'h2000
) (
  input  logic             clk_clk,
  input  logic             reset_reset,
  input  logic [ADC_W-1:0] adc_data,
  input  logic             adc_valid,
  input  logic [7:0]       adc_control,
  input  logic [15:0]      samplenum,
  output logic [15:0]      wavesample
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [15:0]   PRE_CNT  = 16'(PRETRIG);
  localparam logic [15:0]   POST_CNT = 16'(DEPTH - PRETRIG);
  localparam logic [AW-1:0] PRE_OFS  = AW'(PRETRIG);

  state_t           r_state, w_nextState;
  logic [3:0]       r_ctrl, r_ctrlD;
  logic             r_ctrlLoaded;
  logic [AW-1:0]    r_wptr, r_trigPtr, w_raddr;
  logic [15:0]      r_cnt, w_cntInc;
  logic [ADC_W-1:0] r_prev, w_rdata;
  logic             r_prevValid, r_falling;
  logic [15:0]      r_rdIdx, r_status, w_status;
  rd_sel_t          r_rdSel;
  logic             w_armEdge, w_forceEdge, w_clearEdge, w_startCapture;
  logic             w_crossing, w_trigger, w_write, w_unusedCtrl;

  assign w_unusedCtrl   = ^adc_control[7:4];
  assign w_armEdge      = r_ctrl[CTRL_ARM]   & ~r_ctrlD[CTRL_ARM];
  assign w_forceEdge    = r_ctrl[CTRL_FORCE] & ~r_ctrlD[CTRL_FORCE];
  assign w_clearEdge    = r_ctrl[CTRL_CLEAR] & ~r_ctrlD[CTRL_CLEAR];
  assign w_startCapture = w_armEdge && (r_state == IDLE || r_state == DONE);
  assign w_cntInc       = r_cnt + 16'd1;

  assign w_crossing = r_prevValid &&
                      (r_falling ? (r_prev >= TRIG_LEVEL && adc_data <  TRIG_LEVEL)
                                 : (r_prev <  TRIG_LEVEL && adc_data >= TRIG_LEVEL));
  assign w_trigger  = (r_state == WAIT_TRIG) && (w_forceEdge || (adc_valid && w_crossing));
  assign w_write    = adc_valid && (r_state == PRE || r_state == WAIT_TRIG || r_state == POST);

  // First cycle after reset loads both control copies so a held bit makes no edge.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      r_ctrl       <= '0;
      r_ctrlD      <= '0;
      r_ctrlLoaded <= 1'b0;
    end else if (!r_ctrlLoaded) begin
      r_ctrl       <= adc_control[3:0];
      r_ctrlD      <= adc_control[3:0];
      r_ctrlLoaded <= 1'b1;
    end else begin
      r_ctrl  <= adc_control[3:0];
      r_ctrlD <= r_ctrl;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:      if (w_armEdge) w_nextState = PRE;
      PRE:       if (adc_valid && w_cntInc >= PRE_CNT) w_nextState = WAIT_TRIG;
      WAIT_TRIG: if (w_trigger) w_nextState = (adc_valid && POST_CNT == 16'd1) ? DONE : POST;
      POST:      if (adc_valid && w_cntInc >= POST_CNT) w_nextState = DONE;
      DONE:      if (w_armEdge) w_nextState = PRE;
      default:   w_nextState = IDLE;
    endcase
    if (w_clearEdge) begin
      w_nextState = IDLE;
    end
  end

  // The trigger sample itself is the first of the post-trigger writes.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      r_state     <= IDLE;
      r_wptr      <= '0;
      r_trigPtr   <= '0;
      r_cnt       <= '0;
      r_prev      <= '0;
      r_prevValid <= 1'b0;
      r_falling   <= 1'b0;
    end else begin
      r_state <= w_nextState;
      if (w_clearEdge) begin
        r_wptr      <= '0;
        r_trigPtr   <= '0;
        r_cnt       <= '0;
        r_prevValid <= 1'b0;
        r_falling   <= 1'b0;
      end else if (w_startCapture) begin
        r_wptr      <= '0;
        r_cnt       <= '0;
        r_prevValid <= 1'b0;
        r_falling   <= r_ctrl[CTRL_FALLING];
      end else begin
        if (w_write) begin
          r_wptr      <= r_wptr + 1'b1;
          r_prev      <= adc_data;
          r_prevValid <= 1'b1;
        end
        if (w_trigger) begin
          r_trigPtr <= r_wptr;
          r_cnt     <= 16'(adc_valid);
        end else if (w_write && r_state != WAIT_TRIG) begin
          r_cnt <= w_cntInc;
        end
      end
    end
  end

  assign w_raddr  = r_trigPtr - PRE_OFS + r_rdIdx[AW-1:0];
  assign w_status = {r_state == DONE, r_state == WAIT_TRIG || r_state == POST,
                     r_state == PRE, r_falling, 12'(r_trigPtr)};

  // Read pipeline: index register, then RAM output alongside the result selector.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      r_rdIdx  <= '0;
      r_rdSel  <= RD_ZERO;
      r_status <= '0;
    end else begin
      r_rdIdx  <= samplenum;
      r_status <= w_status;
      if (r_rdIdx == STATUS_ADDR) begin
        r_rdSel <= RD_STATUS;
      end else if (r_rdIdx < 16'(DEPTH) && r_state == DONE) begin
        r_rdSel <= RD_SAMPLE;
      end else begin
        r_rdSel <= RD_ZERO;
      end
    end
  end

  adc_wave_ram #(
    .DEPTH(DEPTH),
    .ADC_W(ADC_W)
  ) u_ram (
    .i_clk  (clk_clk),
    .i_we   (w_write),
    .i_waddr(r_wptr),
    .i_wdata(adc_data),
    .i_raddr(w_raddr),
    .o_rdata(w_rdata)
  );

  always_comb begin
    wavesample = 16'h0000;
    case (r_rdSel)
      RD_STATUS: wavesample = r_status;
      RD_SAMPLE: wavesample = 16'(w_rdata);
      default:   wavesample = 16'h0000;
    endcase
  end

endmodule

// File: tb/tb_adc_wave_buffer.sv
// Bench for adc_wave_buffer: drives captures and compares reads with a stream-based model.
module tb_adc_wave_buffer;

  localparam int DEPTH   = 1024;
  localparam int ADC_W   = 14;
  localparam int PRETRIG = 128;
  localparam int POSTN   = DEPTH - PRETRIG;
  localparam logic [13:0] TL = 14'h2000;

  logic        clk_clk = 1'b0;
  logic        reset_reset = 1'b1;
  logic [13:0] adc_data = '0;
  logic        adc_valid = 1'b0;
  logic [7:0]  adc_control = '0;
  logic [15:0] samplenum = 16'hFFFF;
  logic [15:0] wavesample;

  int errors = 0;
  int checks = 0;
  logic [13:0] stream[$];

  always #5 clk_clk = ~clk_clk;

  adc_wave_buffer #(
    .DEPTH(DEPTH),
    .ADC_W(ADC_W),
    .PRETRIG(PRETRIG),
    .TRIG_LEVEL(TL)
  ) dut (
    .clk_clk    (clk_clk),
    .reset_reset(reset_reset),
    .adc_data   (adc_data),
    .adc_valid  (adc_valid),
    .adc_control(adc_control),
    .samplenum  (samplenum),
    .wavesample (wavesample)
  );

  task automatic tick(input int n);
    repeat (n) @(negedge clk_clk);
  endtask

  task automatic setCtrl(input logic [7:0] v);
    adc_control = v;
    tick(3);
  endtask

  task automatic readWord(input logic [15:0] idx, output logic [15:0] val);
    samplenum = idx;
    tick(2);
    val = wavesample;
  endtask

  task automatic feedOne(input logic [13:0] d, input int gapMax);
    if (gapMax > 0) tick(int'($urandom_range(0, gapMax)));
    adc_data  = d;
    adc_valid = 1'b1;
    tick(1);
    adc_valid = 1'b0;
  endtask

  task automatic beginCapture(input bit falling);
    logic [7:0] fb;
    fb = {6'd0, falling, 1'b0};
    adc_valid = 1'b0;
    setCtrl(fb | 8'h08);
    setCtrl(fb);
    setCtrl(fb | 8'h01);
    setCtrl(fb);
  endtask

  // Reference: first sample at or after PRETRIG whose predecessor lies across the level.
  function automatic int findTrigger(input bit falling);
    for (int k = PRETRIG; k < stream.size(); k++) begin
      if (!falling && stream[k-1] <  TL && stream[k] >= TL) return k;
      if ( falling && stream[k-1] >= TL && stream[k] <  TL) return k;
    end
    return -1;
  endfunction

  task automatic doCapture(input bit falling, input int gapMax, input bit pulses,
                           output int t, output logic [15:0] stBefore, output logic [15:0] stAfter);
    logic [7:0] fb;
    int last;
    fb = {6'd0, falling, 1'b0};
    t = findTrigger(falling);
    last = t + POSTN;
    beginCapture(falling);
    for (int k = 0; k < last - 1; k++) begin
      if (pulses && k == 50) begin
        setCtrl(fb | 8'h04);
        setCtrl(fb);
      end
      if (pulses && k == PRETRIG + 60) begin
        setCtrl(fb | 8'h01);
        setCtrl(fb);
      end
      feedOne(stream[k], gapMax);
    end
    readWord(16'hFFFF, stBefore);
    feedOne(stream[last-1], gapMax);
    readWord(16'hFFFF, stAfter);
    for (int k = 0; k < 20; k++) feedOne(14'($urandom), 0);
  endtask

  task automatic test_reset();
    logic [15:0] v;
    reset_reset = 1'b1;
    samplenum = 16'hFFFF;
    tick(3);
    checks++;
    if (wavesample !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL reset_out: got %h expected %h", wavesample, 16'h0000);
    end
    reset_reset = 1'b0;
    tick(3);
    readWord(16'hFFFF, v);
    checks++;
    if (v !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL reset_status: got %h expected %h", v, 16'h0000);
    end
    readWord(16'd0, v);
    checks++;
    if (v !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL idle_sample: got %h expected %h", v, 16'h0000);
    end
  endtask

  task automatic test_clear_arm();
    logic [15:0] v;
    adc_control = 8'h09;
    tick(4);
    readWord(16'hFFFF, v);
    checks++;
    if (v !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL clear_arm_status: got %h expected %h", v, 16'h0000);
    end
    for (int k = 0; k < 10; k++) feedOne(14'($urandom), 0);
    readWord(16'hFFFF, v);
    checks++;
    if (v !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL clear_arm_hold: got %h expected %h", v, 16'h0000);
    end
    setCtrl(8'h00);
  endtask

  task automatic test_ramp_rising();
    int t;
    logic [15:0] sb, sa, v;
    stream.delete();
    for (int k = 0; k < DEPTH + 64; k++) stream.push_back(14'(k * 64));
    doCapture(1'b0, 0, 1'b0, t, sb, sa);
    checks++;
    if (sb[15:14] !== 2'b01) begin
      errors++;
      $display("[TB] FAIL ramp_status_before: got %h expected bits15:14=01", sb);
    end
    checks++;
    if (sa !== 16'h8080) begin
      errors++;
      $display("[TB] FAIL ramp_status_done: got %h expected %h", sa, 16'h8080);
    end
    readWord(16'd128, v);
    checks++;
    if (v !== 16'h2000) begin
      errors++;
      $display("[TB] FAIL ramp_idx128: got %h expected %h", v, 16'h2000);
    end
    readWord(16'd127, v);
    checks++;
    if (v !== 16'h1FC0) begin
      errors++;
      $display("[TB] FAIL ramp_idx127: got %h expected %h", v, 16'h1FC0);
    end
    readWord(16'd1023, v);
    checks++;
    if (v !== {2'b00, stream[t - PRETRIG + 1023]}) begin
      errors++;
      $display("[TB] FAIL ramp_idx1023: got %h expected %h", v, {2'b00, stream[t - PRETRIG + 1023]});
    end
  endtask

  task automatic test_read_range();
    logic [15:0] v;
    readWord(16'd1024, v);
    checks++;
    if (v !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL range_1024: got %h expected %h", v, 16'h0000);
    end
    readWord(16'hFFFE, v);
    checks++;
    if (v !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL range_fffe: got %h expected %h", v, 16'h0000);
    end
    samplenum = 16'd128;
    tick(1);
    checks++;
    if (wavesample !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL latency_a1: got %h expected %h", wavesample, 16'h0000);
    end
    tick(1);
    checks++;
    if (wavesample !== 16'h2000) begin
      errors++;
      $display("[TB] FAIL latency_a2: got %h expected %h", wavesample, 16'h2000);
    end
    samplenum = 16'd127;
    tick(1);
    checks++;
    if (wavesample !== 16'h2000) begin
      errors++;
      $display("[TB] FAIL latency_b1: got %h expected %h", wavesample, 16'h2000);
    end
    tick(1);
    checks++;
    if (wavesample !== 16'h1FC0) begin
      errors++;
      $display("[TB] FAIL latency_b2: got %h expected %h", wavesample, 16'h1FC0);
    end
  endtask

  task automatic test_ramp_falling();
    int t;
    logic [15:0] sb, sa, v;
    stream.delete();
    for (int k = 0; k < DEPTH + 64; k++) stream.push_back(14'(16383 - k * 64));
    doCapture(1'b1, 0, 1'b0, t, sb, sa);
    checks++;
    if (sb[15] !== 1'b0 || sb[12] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL fall_status_before: got %h expected bit15=0 bit12=1", sb);
    end
    checks++;
    if (sa !== 16'h9080) begin
      errors++;
      $display("[TB] FAIL fall_status_done: got %h expected %h", sa, 16'h9080);
    end
    readWord(16'd128, v);
    checks++;
    if (v !== 16'h1FFF) begin
      errors++;
      $display("[TB] FAIL fall_idx128: got %h expected %h", v, 16'h1FFF);
    end
    readWord(16'd127, v);
    checks++;
    if (v !== 16'h203F) begin
      errors++;
      $display("[TB] FAIL fall_idx127: got %h expected %h", v, 16'h203F);
    end
  endtask

  task automatic test_random_capture();
    int t, idx, p;
    logic [15:0] sb, sa, v, expSt;
    for (int f = 0; f < 2; f++) begin
      stream.delete();
      for (int k = 0; k < PRETRIG + 200 + POSTN + 10; k++) stream.push_back(14'($urandom));
      p = PRETRIG + 150;
      stream[p-1] = (f == 1) ? 14'h3FFF : 14'h0000;
      stream[p]   = (f == 1) ? 14'h0000 : 14'h3FFF;
      doCapture(f[0], 3, 1'b1, t, sb, sa);
      expSt = {1'b1, 1'b0, 1'b0, f[0], 12'(t % DEPTH)};
      checks++;
      if (sb[15] !== 1'b0) begin
        errors++;
        $display("[TB] FAIL rand_not_done_early: got %h expected bit15=0", sb);
      end
      checks++;
      if (sa !== expSt) begin
        errors++;
        $display("[TB] FAIL rand_status: got %h expected %h", sa, expSt);
      end
      for (int j = 0; j < 34; j++) begin
        case (j)
          0: idx = 0;
          1: idx = PRETRIG - 1;
          2: idx = PRETRIG;
          3: idx = DEPTH - 1;
          default: idx = int'($urandom_range(0, DEPTH - 1));
        endcase
        readWord(16'(idx), v);
        checks++;
        if (v !== {2'b00, stream[t - PRETRIG + idx]}) begin
          errors++;
          $display("[TB] FAIL rand_idx%0d: got %h expected %h", idx, v, {2'b00, stream[t - PRETRIG + idx]});
        end
      end
    end
  endtask

  task automatic test_force();
    int nPre, idx;
    logic [15:0] st, v, expSt;
    for (int variant = 0; variant < 2; variant++) begin
      nPre = (variant == 0) ? 500 : 300;
      stream.delete();
      for (int k = 0; k < nPre + POSTN; k++)
        stream.push_back((variant == 0) ? 14'h0000 : 14'($urandom_range(0, int'(TL) - 1)));
      beginCapture(1'b0);
      for (int k = 0; k < nPre; k++) feedOne(stream[k], variant * 2);
      readWord(16'hFFFF, st);
      checks++;
      if (st[15:12] !== 4'b0100) begin
        errors++;
        $display("[TB] FAIL force_wait_state: got %h expected bits15:12=0100", st);
      end
      setCtrl(8'h04);
      setCtrl(8'h00);
      for (int k = nPre; k < nPre + POSTN - 1; k++) feedOne(stream[k], variant * 2);
      readWord(16'hFFFF, st);
      checks++;
      if (st[15] !== 1'b0) begin
        errors++;
        $display("[TB] FAIL force_not_done_early: got %h expected bit15=0", st);
      end
      feedOne(stream[nPre + POSTN - 1], 0);
      readWord(16'hFFFF, st);
      expSt = 16'h8000 | 16'(nPre);
      checks++;
      if (st !== expSt) begin
        errors++;
        $display("[TB] FAIL force_status: got %h expected %h", st, expSt);
      end
      for (int j = 0; j < 12; j++) begin
        idx = (j == 0) ? PRETRIG : int'($urandom_range(0, DEPTH - 1));
        readWord(16'(idx), v);
        checks++;
        if (v !== {2'b00, stream[nPre - PRETRIG + idx]}) begin
          errors++;
          $display("[TB] FAIL force_idx%0d: got %h expected %h", idx, v, {2'b00, stream[nPre - PRETRIG + idx]});
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] st, v;
    beginCapture(1'b0);
    for (int k = 0; k < PRETRIG; k++) feedOne(14'h0000, 0);
    for (int k = 0; k < 11; k++) feedOne(14'h3FFF, 0);
    readWord(16'hFFFF, st);
    checks++;
    if (st[15:13] !== 3'b010) begin
      errors++;
      $display("[TB] FAIL mid_in_post: got %h expected bits15:13=010", st);
    end
    adc_control = 8'h01;
    tick(1);
    reset_reset = 1'b1;
    tick(1);
    checks++;
    if (wavesample !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL mid_reset_out: got %h expected %h", wavesample, 16'h0000);
    end
    tick(2);
    reset_reset = 1'b0;
    tick(4);
    readWord(16'hFFFF, st);
    checks++;
    if (st[15:13] !== 3'b000) begin
      errors++;
      $display("[TB] FAIL mid_reset_idle: got %h expected bits15:13=000", st);
    end
    for (int k = 0; k < 20; k++) feedOne(14'($urandom), 0);
    readWord(16'hFFFF, st);
    checks++;
    if (st[15:13] !== 3'b000) begin
      errors++;
      $display("[TB] FAIL mid_no_rearm: got %h expected bits15:13=000", st);
    end
    setCtrl(8'h00);
    setCtrl(8'h01);
    readWord(16'hFFFF, st);
    checks++;
    if (st[15:13] !== 3'b001) begin
      errors++;
      $display("[TB] FAIL mid_rearm_pre: got %h expected bits15:13=001", st);
    end
    readWord(16'd5, v);
    checks++;
    if (v !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL sample_outside_done: got %h expected %h", v, 16'h0000);
    end
    setCtrl(8'h00);
  endtask

  initial begin
    $display("[TB] adc_wave_buffer bench start");
    test_reset();
    test_clear_arm();
    test_ramp_rising();
    test_read_range();
    test_ramp_falling();
    test_random_capture();
    test_force();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/adc_wave_buffer.md
ADC_WAVE_BUFFER -- requirements
Module: adc_wave_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 1024, buffer depth in samples (power of two, 2..32768).
REQ-002 SHALL have parameter ADC_W, default 14, ADC sample width (<=16).
REQ-003 SHALL have parameter PRETRIG, default 128, samples kept before trigger (<DEPTH).
REQ-004 SHALL have parameter TRIG_LEVEL, default 14'h2000, trigger threshold (offset binary, ADC_W bits).
REQ-005 SHALL have port: clk_clk  in  1  single clock, all logic on rising edge.
REQ-006 SHALL have port: reset_reset  in  1  reset, synchronous, active-high.
REQ-007 SHALL have port: adc_data  in  ADC_W  ADC sample, offset binary.
REQ-008 SHALL have port: adc_valid  in  1  adc_data qualifier, one sample per asserted cycle.
REQ-009 SHALL have port: adc_control  in  8  CPU control PIO: [0] ARM, [1] FALLING (trigger slope), [2] FORCE, [3] CLEAR, [7:4] ignored.
REQ-010 SHALL have port: samplenum  in  16  CPU read index; 16'hFFFF selects status word.
REQ-011 SHALL have port: wavesample  out  16  sample or status returned to CPU PIO.

Function
REQ-012 SHALL implement states IDLE, PRE, WAIT_TRIG, POST, DONE.
REQ-013 SHALL register adc_control each cycle; ARM, FORCE, CLEAR act on rising edge (0->1 between consecutive registered values).
REQ-014 IDLE: ARM edge -> PRE; write pointer and fill counter cleared.
REQ-015 PRE: each adc_valid writes adc_data at wptr, wptr increments mod DEPTH; after PRETRIG writes -> WAIT_TRIG.
REQ-016 WAIT_TRIG: keep writing circularly; trigger when adc_valid and (FALLING=0: prev<TRIG_LEVEL and cur>=TRIG_LEVEL; FALLING=1: prev>=TRIG_LEVEL and cur<TRIG_LEVEL), or on FORCE edge.
REQ-017 prev SHALL be the last valid sample written in PRE/WAIT_TRIG; first sample after ARM never triggers.
REQ-018 On trigger, trig_ptr SHALL latch the address of the triggering sample (FORCE: next address to be written); -> POST.
REQ-019 POST: continue writing; after DEPTH-PRETRIG writes counted from trig_ptr inclusive -> DONE; writes stop.
REQ-020 DONE: buffer frozen; ARM edge -> PRE (new capture); otherwise hold.
REQ-021 CLEAR edge in any state -> IDLE next cycle; CLEAR wins over simultaneous ARM or FORCE.
REQ-022 ARM edge outside IDLE/DONE SHALL be ignored; FORCE edge outside WAIT_TRIG SHALL be ignored.
REQ-023 Read: for samplenum<DEPTH in DONE, wavesample = zero-extended RAM[(trig_ptr - PRETRIG + samplenum) mod DEPTH]; index 0 = oldest pre-trigger sample, index PRETRIG = trigger sample.
REQ-024 Read latency SHALL be exactly 2 cycles from samplenum change to wavesample update (address register, registered RAM output).
REQ-025 samplenum>=DEPTH (not 16'hFFFF), or any sample index outside DONE, SHALL return 16'h0000.
REQ-026 samplenum=16'hFFFF SHALL return status {DONE, WAIT_TRIG|POST, PRE, FALLING_latched, 12'(trig_ptr)} with the same 2-cycle latency.
REQ-027 FALLING SHALL be sampled at the ARM edge and held for that capture.
REQ-028 Address arithmetic SHALL wrap modulo DEPTH using log2(DEPTH)-bit pointers; no out-of-range RAM access.

Reset
REQ-029 reset_reset SHALL force state IDLE, wptr=0, trig_ptr=0, counters=0, registered adc_control=0, wavesample=16'h0000 on the next edge.
REQ-030 Reset mid-capture SHALL abandon capture; RAM content need not be cleared; no ARM edge is generated by control already high at reset release (registered copy reloads before edge detection).

Structure
REQ-031 Package adc_wave_pkg SHALL hold state enum, adc_control bit indices, STATUS_ADDR=16'hFFFF.
REQ-032 Sub-module adc_wave_ram SHALL be a simple dual-port RAM (one write port, one registered read port), DEPTH x ADC_W, inferable as block RAM.

Verification
REQ-033 ARM, ramp 0..16383 step 64 valid every cycle, DEPTH=1024 -> DONE; index 128 reads 16'h2000, index 127 reads 16'h1FC0.
REQ-034 FALLING=1, ARM, falling ramp -> trigger at first sample <16'h2000; status bit12 set (FALLING), bit15 set after 896 post samples.
REQ-035 ARM then constant 0 input, FORCE edge after 500 cycles -> DONE after 896 further valids; index 128 reads 0.
REQ-036 CLEAR and ARM edges same cycle in IDLE -> state stays IDLE; status reads 16'h0000.
REQ-037 Reset asserted in POST with adc_control[0]=1 held -> IDLE, no new capture until ARM goes 0 then 1.
REQ-038 samplenum=1024 in DONE -> 16'h0000; samplenum change -> wavesample updates exactly 2 cycles later.
